div_unit: RTL and testbench

Iterative 32-bit radix-2 divider for the EX stage. It computes MIPS DIV/DIVU results as a {remainder, quotient} pair, which EX forwards to the EX/MEM register as ex_hi/ex_lo with ex_whilo set. While a divide is in flight, EX holds start_i and raises its stall request, so the EX/MEM register inserts bubbles until ready_o is asserted.

---
 rtl/div_unit_pkg.sv | 25 ++
 rtl/div_unit.sv | 122 ++++++++++++
 tb/tb_div_unit.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared codes and helpers for the iterative divider
package div_unit_pkg;

  localparam int RegBus       = 32;
  localparam int DoubleRegBus = 64;

  localparam logic              RstEnable         = 1'b1;
  localparam logic [RegBus-1:0] ZeroWord          = 32'h0000_0000;
  localparam logic              DivStart          = 1'b1;
  localparam logic              DivStop           = 1'b0;
  localparam logic              DivResultReady    = 1'b1;
  localparam logic              DivResultNotReady = 1'b0;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  function automatic logic [RegBus-1:0] neg32(input logic [RegBus-1:0] v);
    return ~v + 32'd1;
  endfunction

endpackage

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative 32-bit radix-2 restoring divider for DIV/DIVU
module div_unit
  import div_unit_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    signed_div_i,
  input  logic [RegBus-1:0]       opdata1_i,
  input  logic [RegBus-1:0]       opdata2_i,
  input  logic                    start_i,
  input  logic                    annul_i,
  output logic [DoubleRegBus-1:0] result_o,
  output logic                    ready_o
);

  div_state_e              state_q;
  logic [5:0]              cnt_q;
  logic [DoubleRegBus-1:0] work_q;     // {partial_rem, quot}
  logic [RegBus-1:0]       dvsr_q;     // divisor magnitude
  logic                    dvd_neg_q;  // signed mode and dividend negative
  logic                    dvs_neg_q;  // signed mode and divisor negative
  logic [DoubleRegBus-1:0] result_q;
  logic                    ready_q;

  logic                    dvd_neg_d;
  logic                    dvs_neg_d;
  logic [RegBus-1:0]       dvd_abs_d;
  logic [RegBus-1:0]       dvsr_abs_d;
  logic [RegBus:0]         diff_d;
  logic [RegBus-1:0]       quot_fix_d;
  logic [RegBus-1:0]       rem_fix_d;

  always_comb begin
    dvd_neg_d  = signed_div_i & opdata1_i[31];
    dvs_neg_d  = signed_div_i & opdata2_i[31];
    dvd_abs_d  = dvd_neg_d ? neg32(opdata1_i) : opdata1_i;
    dvsr_abs_d = dvs_neg_d ? neg32(opdata2_i) : opdata2_i;
    // Trial subtract of the shifted partial remainder; diff_d[32] is the borrow.
    diff_d     = {1'b0, work_q[62:32], work_q[31]} - {1'b0, dvsr_q};
    quot_fix_d = (dvd_neg_q ^ dvs_neg_q) ? neg32(work_q[31:0]) : work_q[31:0];
    rem_fix_d  = dvd_neg_q ? neg32(work_q[63:32]) : work_q[63:32];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      state_q   <= DivFree;
      cnt_q     <= 6'd0;
      work_q    <= '0;
      dvsr_q    <= ZeroWord;
      dvd_neg_q <= 1'b0;
      dvs_neg_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= DivResultNotReady;
    end else begin
      case (state_q)
        DivFree: begin
          if (start_i == DivStart && !annul_i) begin
            dvd_neg_q <= dvd_neg_d;
            dvs_neg_q <= dvs_neg_d;
            dvsr_q    <= dvsr_abs_d;
            if (opdata2_i == ZeroWord) begin
              state_q <= DivByZero;
            end else begin
              state_q <= DivOn;
              cnt_q   <= 6'd0;
              work_q  <= {ZeroWord, dvd_abs_d};
            end
          end else begin
            ready_q  <= DivResultNotReady;
            result_q <= '0;
          end
        end
        DivByZero: begin
          if (annul_i) begin
            state_q  <= DivFree;
            ready_q  <= DivResultNotReady;
            result_q <= '0;
          end else begin
            state_q <= DivEnd;
            work_q  <= '0;
          end
        end
        DivOn: begin
          if (annul_i) begin
            state_q  <= DivFree;
            cnt_q    <= 6'd0;
            ready_q  <= DivResultNotReady;
            result_q <= '0;
          end else if (cnt_q != 6'd32) begin
            if (diff_d[32]) begin
              work_q <= {work_q[62:0], 1'b0};
            end else begin
              work_q <= {diff_d[31:0], work_q[30:0], 1'b1};
            end
            cnt_q <= cnt_q + 6'd1;
          end else begin
            result_q <= {rem_fix_d, quot_fix_d};
            ready_q  <= DivResultReady;
            cnt_q    <= 6'd0;
            state_q  <= DivEnd;
          end
        end
        DivEnd: begin
          // Arriving from BYZERO the flag is still low; raise it for at least one cycle.
          if (ready_q == DivResultNotReady) begin
            ready_q  <= DivResultReady;
            result_q <= work_q;
          end else if (start_i == DivStop) begin
            state_q  <= DivFree;
            ready_q  <= DivResultNotReady;
            result_q <= '0;
          end
        end
        default: state_q <= DivFree;
      endcase
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking bench for div_unit
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  div_unit dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  // Drives one divide, scrambles the operands after E0, then checks latency,
  // result, hold behaviour and the clear after start_i drops.
  task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp_res, input int exp_lat, input int hold,
                        input string name);
    int lat;
    logic [63:0] e;
    exp_q.push_back(exp_res);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    @(posedge clk); #1;
    opdata1_i    = $urandom;
    opdata2_i    = $urandom;
    signed_div_i = ~sgn;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!ready_o && lat < 100);
    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles, expected %0d", name, lat, exp_lat);
    end
    e = exp_q.pop_front();
    checks++;
    if (result_o !== e) begin
      errors++;
      $display("FAIL %s result: got %h, expected %h", name, result_o, e);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checks++;
      if (ready_o !== 1'b1 || result_o !== e) begin
        errors++;
        $display("FAIL %s hold%0d: got ready=%b result=%h, expected ready=1 result=%h",
                 name, i, ready_o, result_o, e);
      end
    end
    start_i = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      errors++;
      $display("FAIL %s clear: got ready=%b result=%h, expected ready=0 result=0",
               name, ready_o, result_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      errors++;
      $display("FAIL reset: got ready=%b result=%h, expected ready=0 result=0", ready_o, result_o);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    do_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 3, "divu_100_7");
    do_div(1'b1, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 33, 0, "div_m7_2");
    do_div(1'b1, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33, 0, "div_7_m2");
  endtask

  task automatic test_boundaries();
    do_div(1'b1, 32'h12345678, 32'h0, 64'h0, 2, 2, "div_by_zero");
    do_div(1'b0, 32'h12345678, 32'h0, 64'h0, 2, 0, "divu_by_zero");
    do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33, 0, "div_min_m1");
    do_div(1'b0, 32'hFFFFFFFF, 32'h00000001, 64'h00000000_FFFFFFFF, 33, 0, "divu_max_1");
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) begin
      logic [31:0] ua, ub;
      ua = $urandom;
      ub = $urandom_range(1, 32'h7FFFFFFF);
      do_div(1'b0, ua, ub, {ua % ub, ua / ub}, 33, 0, "divu_rand");
    end
    for (int i = 0; i < 4; i++) begin
      int sa, sb, q, r;
      sa = $urandom;
      sb = $urandom_range(2, 32'h7FFFFFFF);
      if ($urandom_range(0, 1) == 1) sb = -sb;
      q = sa / sb;
      r = sa % sb;
      do_div(1'b1, sa, sb, {r, q}, 33, 0, "div_rand");
    end
  endtask

  task automatic test_annul();
    bit rose;
    signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    @(posedge clk); #1;
    repeat (9) begin @(posedge clk); #1; end
    annul_i = 1'b1; start_i = 1'b0;
    @(posedge clk); #1;
    annul_i = 1'b0;
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      errors++;
      $display("FAIL annul_clear: got ready=%b result=%h, expected ready=0 result=0", ready_o, result_o);
    end
    rose = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ready_o !== 1'b0) rose = 1'b1;
    end
    checks++;
    if (rose) begin
      errors++;
      $display("FAIL annul_no_ready: got ready rising, expected ready to stay 0");
    end
    do_div(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33, 0, "divu_9_3_after_annul");
  endtask

  task automatic test_async_reset();
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    repeat (15) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      errors++;
      $display("FAIL rst_mid_on: got ready=%b result=%h, expected ready=0 result=0", ready_o, result_o);
    end
    start_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    // Let a result become visible, then clear it without any clock edge.
    start_i = 1'b1;
    for (int n = 0; n < 100 && ready_o !== 1'b1; n++) begin @(posedge clk); #1; end
    checks++;
    if (ready_o !== 1'b1 || result_o !== 64'h00000002_0000000E) begin
      errors++;
      $display("FAIL pre_rst_result: got ready=%b result=%h, expected ready=1 result=000000020000000e",
               ready_o, result_o);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      errors++;
      $display("FAIL rst_in_end: got ready=%b result=%h, expected ready=0 result=0", ready_o, result_o);
    end
    start_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 1, "divu_100_7_after_rst");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_random();
    test_annul();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
